// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential next PC; wraps naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry registered FIFO holding fetched {pc, instr} pairs.
// Slot 0 is always the head, so the head outputs come straight from flops.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;

  // Storage and occupancy; flush beats push/pop, and the owner never
  // pushes into a full buffer without a simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head       = slot0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, captures
// the returned word into a 2-entry buffer and presents it to decode.
//
// Decode handshake: Instr_Valid_o/Instr_o/Instr_PC_o/Instr_PC_Plus4_o come
// from registers only; a transfer happens on a rising edge where
// Instr_Valid_o & Instr_Ready_i, and while valid is high without ready the
// head payload is held unchanged. Instr_Valid_o never depends on
// Instr_Ready_i. A redirect flushes everything except a head transferred
// on that same edge.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Fetch_Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
  output logic                  Instr_Valid_o,
  input  logic                  Instr_Ready_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] Instr_PC_o,
  output logic [DATA_WIDTH-1:0] Instr_PC_Plus4_o,
  output logic                  Misaligned_o
);

  localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [1:0]            buf_count;
  logic                  buf_full;
  logic                  head_valid;
  fetch_entry_t          head;
  fetch_entry_t          din;
  logic                  push;
  logic                  pop;

  assign Fetch_Address_o = pc;
  assign redirect_pc     = {Redirect_Target_i[DATA_WIDTH-1:2], 2'b00};

  assign buf_full = (buf_count == BUF_FULL);
  assign pop      = head_valid & Instr_Ready_i;
  assign push     = ~Redirect_i & (~buf_full | pop);

  assign din.pc    = pc;
  assign din.instr = Instruction_i;

  // Program counter: redirect wins, otherwise advance only when the word
  // presented this cycle is actually captured (stall re-presents it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pc <= RESET_PC;
    else if (Redirect_i) pc <= redirect_pc;
    else if (push)       pc <= pc_inc(pc);
  end

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         Misaligned_o <= 1'b0;
    else if (Redirect_i && (Redirect_Target_i[1:0] != 2'b00)) Misaligned_o <= 1'b1;
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (reset),
    .push       (push),
    .pop        (pop),
    .flush      (Redirect_i),
    .din        (din),
    .count      (buf_count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign Instr_Valid_o    = head_valid;
  assign Instr_o          = head_valid ? head.instr     : NOP_INSTR;
  assign Instr_PC_o       = head_valid ? head.pc        : '0;
  assign Instr_PC_Plus4_o = head_valid ? pc_inc(head.pc) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, stepwise checks and an
// in-order scoreboard of every instruction decode accepts.
module tb_fetch_unit;

  localparam logic [31:0] P0  = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_address;
  logic [31:0] instruction;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .Fetch_Address_o   (fetch_address),
    .Instruction_i     (instruction),
    .Redirect_i        (redirect),
    .Redirect_Target_i (redirect_target),
    .Instr_Valid_o     (instr_valid),
    .Instr_Ready_i     (instr_ready),
    .Instr_o           (instr),
    .Instr_PC_o        (instr_pc),
    .Instr_PC_Plus4_o  (instr_pc_plus4),
    .Misaligned_o      (misaligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word k at address bits [16:2] holds 0x1000_0000 + k
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {17'd0, a[16:2]};
  endfunction
  assign instruction = rom_word(fetch_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: advance one edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_pc"},    instr_pc, 32'd0);
    check({tag, "_plus4"}, instr_pc_plus4, 32'd0);
    check({tag, "_mis"},   32'(misaligned), 32'd0);
    check({tag, "_addr"},  fetch_address, P0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"},    instr_pc, pc);
    check({tag, "_instr"}, instr, rom_word(pc));
    check({tag, "_plus4"}, instr_pc_plus4, pc + 32'd4);
  endtask

  // scoreboard: every accepted head must match the next expected PC
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e);
        check("sb_instr", instr, rom_word(e));
        check("sb_plus4", instr_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'd0;
    tick();
    tick();
    check_reset_outputs("rst0");
    reset = 1'b0;

    // streaming, one per cycle
    instr_ready = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back(P0 + 32'(4 * k));
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("s1_addr", fetch_address, P0 + 32'(4 * k));
      check_head("s1", P0 + 32'(4 * (k - 1)));
    end
    instr_ready = 1'b0;

    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst1");
    tick();
    tick();
    reset = 1'b0;

    // stall with ready low: buffer fills, PC holds
    tick();
    check_head("st1", P0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("st_addr", fetch_address, P0 + 32'd8);
      check_head("st_hold", P0);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(P0 + 32'(4 * k));
    for (int k = 7; k <= 10; k++) begin
      tick();
      check_head("rs", P0 + 32'(4 * (k - 6)));
      check("rs_addr", fetch_address, P0 + 32'(4 * (k - 4)));
    end

    // redirect while full, with a simultaneous pop of the head
    redirect = 1'b1;
    redirect_target = 32'h0040_0040;
    tick();
    check("rd_valid", 32'(instr_valid), 32'd0);
    check("rd_addr", fetch_address, 32'h0040_0040);
    check("rd_instr", instr, NOP);
    redirect = 1'b0;
    exp_q.push_back(32'h0040_0040);
    exp_q.push_back(32'h0040_0044);
    tick();
    check_head("rd_first", 32'h0040_0040);
    check("rd_first_word", instr, 32'h1000_0010);
    tick();
    check_head("rd_second", 32'h0040_0044);

    // misaligned redirect target
    redirect = 1'b1;
    redirect_target = 32'h0040_0022;
    tick();
    check("mis_set", 32'(misaligned), 32'd1);
    check("mis_addr", fetch_address, 32'h0040_0020);
    check("mis_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b0;
    exp_q.push_back(32'h0040_0020);
    tick();
    check_head("mis_head", 32'h0040_0020);
    check("mis_word", instr, 32'h1000_0008);

    // back-to-back redirects, last one wins, then PC wrap
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFF0;
    tick();
    check("b2b_valid0", 32'(instr_valid), 32'd0);
    check("b2b_addr0", fetch_address, 32'hFFFF_FFF0);
    redirect_target = 32'hFFFF_FFF8;
    tick();
    check("b2b_valid1", 32'(instr_valid), 32'd0);
    check("b2b_addr1", fetch_address, 32'hFFFF_FFF8);
    check("b2b_mis", 32'(misaligned), 32'd1);
    redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    check_head("wr0", 32'hFFFF_FFF8);
    check("wr0_word", instr, 32'h1000_7FFE);
    check("wr0_addr", fetch_address, 32'hFFFF_FFFC);
    tick();
    check_head("wr1", 32'hFFFF_FFFC);
    check("wr1_plus4", instr_pc_plus4, 32'd0);
    check("wr1_addr", fetch_address, 32'd0);
    tick();
    check_head("wr2", 32'd0);
    check("wr2_addr", fetch_address, 32'd4);
    instr_ready = 1'b0;

    // fill and stall, then reset mid-stall
    tick();
    check("ms_addr0", fetch_address, 32'd8);
    tick();
    check("ms_addr1", fetch_address, 32'd8);
    check("ms_mis", 32'(misaligned), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst2");
    tick();
    reset = 1'b0;
    check("post_addr", fetch_address, P0);
    instr_ready = 1'b1;
    exp_q.push_back(P0);
    tick();
    check_head("post", P0);
    @(negedge clk);
    #1 instr_ready = 1'b0;
    tick();
    tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of Program_Memory; owns the program counter.
- Drives the combinational ROM address every cycle and captures the returned word with its PC.
- Holds captured instructions in a 2-entry buffer and hands them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute, which flush buffered instructions.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0040_0000, PC loaded on reset (text base; bits [16:2] index ROM word 0).
- BUF_DEPTH, 2, instruction buffer entries (fixed at 2; other values unsupported).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Fetch_Address_o  output  DATA_WIDTH  current PC, wired to Program_Memory Address_i.
- Instruction_i  input  DATA_WIDTH  ROM word for Fetch_Address_o, valid in the same cycle.
- Redirect_i  input  1  take branch/jump this cycle.
- Redirect_Target_i  input  DATA_WIDTH  new PC when Redirect_i=1.
- Instr_Valid_o  output  1  buffer head holds a valid instruction.
- Instr_Ready_i  input  1  decode accepts the head this cycle.
- Instr_o  output  DATA_WIDTH  head instruction; 32'h0000_0013 (NOP) when not valid.
- Instr_PC_o  output  DATA_WIDTH  PC of head instruction; 0 when not valid.
- Instr_PC_Plus4_o  output  DATA_WIDTH  Instr_PC_o+4 (mod 2^32); 0 when not valid.
- Misaligned_o  output  1  sticky flag: a redirect target had [1:0]!=0.

Behaviour:
- Reset (async, takes effect immediately):
  - PC=RESET_PC; buffer count=0.
  - Instr_Valid_o=0, Instr_o=NOP, Instr_PC_o=0, Instr_PC_Plus4_o=0, Misaligned_o=0.
- Fetch_Address_o = PC register; it is combinational from the register only (no path from Instruction_i).
- pop = Instr_Valid_o & Instr_Ready_i.
- push = ~Redirect_i & (count<2 | pop). On push, {PC, Instruction_i} is written to the tail and PC <= PC+4. PC wraps 32'hFFFF_FFFC -> 0.
- Stall: when count==2 and no pop, PC holds and the same address is presented again.
- Latency: one cycle from address presentation to Instr_Valid_o, because the buffer output is registered.
- Throughput: with Instr_Ready_i held high, one instruction per cycle.
- Redirect_i=1 has highest priority:
  - buffer count <= 0 and contents are discarded;
  - PC <= {Redirect_Target_i[31:2], 2'b00};
  - no push that cycle;
  - a simultaneous pop is still a legal handshake. That instruction is the one consumed by decode; nothing else issues.
- Redirect with Redirect_Target_i[1:0]!=0: Misaligned_o <= 1 and stays 1 until reset. Fetch proceeds at the aligned address.
- Back-to-back redirects: the last one wins; Instr_Valid_o stays 0 until one cycle after the first non-redirect cycle.
- Simultaneous push and pop with count==2: count stays 2, the head advances and the new word enters the tail.
- Instr_o, Instr_PC_o and Instr_PC_Plus4_o are held stable while Instr_Valid_o=1 and Instr_Ready_i=0.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately; the first fetch after deassertion is RESET_PC.

Decomposition:
- Shared package holds:
  - RESET_PC default;
  - NOP_INSTR = 32'h0000_0013;
  - PC_STEP = 4;
  - the buffer entry type {pc, instr} (64 bits).
- One sub-module, fetch_buffer: a 2-entry registered FIFO with push/pop/flush, count, and head outputs.
- fetch_unit contains the PC register, next-PC mux, push/pop logic and the sticky flag.

Test Plan:
- Reset release, Ready=1, ROM word k = 32'h1000_0000+k → Fetch_Address_o = 0x00400000, 0x00400004, …; from cycle 1, one valid per cycle with Instr_o = 0x10000000, 0x10000001, … and Instr_PC_Plus4_o = Instr_PC_o+4.
- Ready=0 for 5 cycles after the first valid → count saturates at 2; Fetch_Address_o holds at 0x00400008; head stays 0x10000000. On Ready=1 the stream resumes with no loss or duplication.
- Redirect_i=1, target 0x00400040, while count=2 and Ready=1 → next cycle Instr_Valid_o=0 and Fetch_Address_o=0x00400040; the cycle after, Instr_PC_o=0x00400040 and Instr_o=0x10000010.
- Redirect target 0x00400022 → Misaligned_o=1 from the next edge onward; fetch at 0x00400020; flag persists through later redirects until reset.
- PC forced near top via redirect to 0xFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; Instr_PC_Plus4_o for 0xFFFFFFFC equals 0.
- Assert reset asynchronously mid-cycle during a stall → outputs go to reset values before the next edge; first fetch after release is 0x00400000.
